// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART transmitter between NREQ byte producers.
// It latches one byte per frame, pulses the start input, tracks ready, and recovers from a transmitter that never starts.
module uart_tx_arbiter #(
    parameter int NREQ          = 4,
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_accept,
    output logic                    tx_ctrl,
    output logic [7:0]              tx_byte,
    input  logic                    transmit_ready,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    err_timeout,
    output logic [2:0]              dbg_state
);

    localparam int PW = $clog2(NREQ);
    localparam int TW = $clog2(START_TIMEOUT);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TW-1:0] TO_LAST  = TW'(START_TIMEOUT - 2);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PTR_MAX  = PW'(NREQ - 1);
    localparam logic [PW:0]   NREQ_W   = (PW+1)'(NREQ);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] req_accept_q, req_accept_d;
    logic            tx_ctrl_q, tx_ctrl_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic [PW-1:0]   grant_id_q, grant_id_d;
    logic            busy_q, busy_d;
    logic            err_timeout_q, err_timeout_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            hi_seen_q, hi_seen_d;

    logic            pick_found;
    logic [PW-1:0]   pick_idx;
    logic [PW-1:0]   pick_cand;
    logic [PW:0]     pick_scan;
    logic            start_frame;

    // Handshake: a requester raises req_valid[i] with req_data[i] stable and holds both
    // until req_accept[i] pulses; that pulse transfers ownership of the byte to the arbiter.

    // First pending requester at or after rr_ptr, wrapping past the highest index.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_scan  = '0;
        pick_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            pick_scan = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (pick_scan >= NREQ_W) begin
                pick_scan = pick_scan - NREQ_W;
            end
            pick_cand = pick_scan[PW-1:0];
            if (!pick_found && req_valid[pick_cand]) begin
                pick_found = 1'b1;
                pick_idx   = pick_cand;
            end
        end
    end

    assign start_frame = transmit_ready && pick_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            req_accept_q  <= '0;
            tx_ctrl_q     <= 1'b0;
            tx_byte_q     <= '0;
            grant_id_q    <= '0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            to_cnt_q      <= '0;
            gap_cnt_q     <= '0;
            hi_seen_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            req_accept_q  <= req_accept_d;
            tx_ctrl_q     <= tx_ctrl_d;
            tx_byte_q     <= tx_byte_d;
            grant_id_q    <= grant_id_d;
            busy_q        <= busy_d;
            err_timeout_q <= err_timeout_d;
            to_cnt_q      <= to_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            hi_seen_q     <= hi_seen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_frame) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!transmit_ready) begin
                    state_d = S_WAIT_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = S_GAP;
                end
            end
            S_WAIT_DONE: begin
                if (transmit_ready && hi_seen_q) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        req_accept_d  = '0;
        tx_ctrl_d     = 1'b0;
        tx_byte_d     = tx_byte_q;
        grant_id_d    = grant_id_q;
        err_timeout_d = 1'b0;
        to_cnt_d      = to_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        hi_seen_d     = hi_seen_q;
        busy_d        = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start_frame) begin
                    tx_byte_d              = req_data[{pick_idx, 3'b000} +: 8];
                    grant_id_d             = pick_idx;
                    req_accept_d[pick_idx] = 1'b1;
                    tx_ctrl_d              = 1'b1;
                    rr_ptr_d               = (pick_idx == PTR_MAX) ? '0 : pick_idx + 1'b1;
                end
            end
            S_ISSUE: begin
                to_cnt_d = '0;
            end
            S_WAIT_BUSY: begin
                // Abort on the edge where the counter would reach START_TIMEOUT-1.
                if (!transmit_ready) begin
                    hi_seen_d = 1'b0;
                end else if (to_cnt_q == TO_LAST) begin
                    err_timeout_d = 1'b1;
                    gap_cnt_d     = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!transmit_ready) begin
                    hi_seen_d = 1'b0;
                end else if (hi_seen_q) begin
                    gap_cnt_d = '0;
                end else begin
                    hi_seen_d = 1'b1;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: begin
                hi_seen_d = 1'b0;
            end
        endcase
    end

    assign req_accept  = req_accept_q;
    assign tx_ctrl     = tx_ctrl_q;
    assign tx_byte     = tx_byte_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign err_timeout = err_timeout_q;
    assign dbg_state   = state_q;

    a_accept_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_accept));
    a_accept_with_ctrl: assert property (@(posedge clk) disable iff (rst)
        ((req_accept != '0) == tx_ctrl));
    a_ctrl_single: assert property (@(posedge clk) disable iff (rst)
        tx_ctrl |=> !tx_ctrl);
    a_err_single: assert property (@(posedge clk) disable iff (rst)
        err_timeout |=> !err_timeout);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter between NREQ byte producers. It accepts a byte from one requester, latches it, and pulses the transmitter's start input. It holds the byte stable for the whole frame and tracks the transmitter's ready line to detect frame completion. A watchdog recovers from a transmitter that never starts.

Parameters:
NREQ, 4, number of requesters (2..8)
GAP_CYCLES, 16, idle cycles enforced between frames (>=1)
START_TIMEOUT, 64, max cycles in WAIT_BUSY before aborting (>=2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req_valid  input  NREQ  requester i has a byte pending
req_data  input  8*NREQ  byte for requester i, at bits [8i+7:8i]
req_accept  output  NREQ  one-cycle pulse: byte of requester i latched
tx_ctrl  output  1  start pulse to transmitter
tx_byte  output  8  byte to transmitter, held stable from ISSUE until leaving WAIT_DONE
transmit_ready  input  1  transmitter ready/idle indication
grant_id  output  $clog2(NREQ)  index of requester owning the current frame
busy  output  1  high in every state except IDLE
err_timeout  output  1  one-cycle pulse when the START_TIMEOUT abort fires

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high, sampled on posedge clk.
- Reset values: state=IDLE, rr_ptr=0, req_accept=0, tx_ctrl=0, tx_byte=0, grant_id=0, busy=0, err_timeout=0, counters=0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: when transmit_ready=1 and any req_valid=1, select the first set bit searching from rr_ptr upward, modulo NREQ. In the same edge:
  - latch req_data of the winner into tx_byte;
  - set grant_id to the winner;
  - pulse req_accept[winner] for one cycle;
  - go to ISSUE.
  - If transmit_ready=0, stay in IDLE; no accept.
- ISSUE: tx_ctrl=1 for exactly one cycle, then go to WAIT_BUSY. Load the timeout counter with 0.
- WAIT_BUSY: wait for transmit_ready=0, then go to WAIT_DONE.
  - The counter increments each cycle.
  - If the counter reaches START_TIMEOUT-1 while transmit_ready is still 1: pulse err_timeout, drop the byte (it is not retried), and go to GAP.
- WAIT_DONE: wait for transmit_ready=1 sampled on 2 consecutive cycles, then go to GAP. A single-cycle high (end-of-frame glitch) is ignored and the consecutive-high count restarts.
- GAP: count GAP_CYCLES cycles, then go to IDLE. tx_byte holds its last value.
- Fairness: rr_ptr is updated to (winner+1) mod NREQ on each accept. The highest index wraps to 0.
- req_valid deasserted during ISSUE/WAIT/GAP has no effect. The byte is already owned by the arbiter.
- Requesters hold req_valid and req_data until their req_accept pulse. After the accept, the requester may present a new byte next cycle. That byte waits for the next arbitration.
- Simultaneous requests: only one accept per frame. Losers are not acknowledged.
- Reset mid-frame: an immediate return to reset values. tx_ctrl and req_accept drop the same edge. No pending accept is replayed.
- Throughput bound: at most one accepted byte per (frame + GAP_CYCLES + 4) cycles.

Test Plan:
- Single request: NREQ=4, reset, req_valid=0001, req_data[7:0]=0xA5 -> req_accept[0] pulses 1 cycle. tx_byte=0xA5 and grant_id=0 next cycle. tx_ctrl pulses once. tx_byte stays 0xA5 until the transmitter's ready returns high for 2 cycles. busy falls GAP_CYCLES later.
- Round-robin: all four valid with bytes 0x10,0x11,0x12,0x13 held high -> transmitted order is 0x10,0x11,0x12,0x13,0x10. Each accept comes after the previous frame's GAP.
- Pointer wrap/skip: rr_ptr=3 after granting 2; req_valid=0011 -> grant 0, then 1; requester 3 is never accepted.
- Ready glitch: a transmitter model drives ready 1 for one cycle, then 0, then steady 1 at the end of a frame -> the arbiter stays in WAIT_DONE through the glitch. It exits only after the 2-cycle high.
- Start timeout: transmitter model keeps ready=1 and ignores tx_ctrl -> err_timeout pulses exactly START_TIMEOUT cycles after ISSUE. The next request is served after GAP_CYCLES. The dropped byte is not resent.
- Reset mid-frame: assert rst for 1 cycle during WAIT_DONE -> next cycle all outputs are 0 and state is IDLE. A held req_valid=0100 is then granted to requester 2 with rr_ptr starting at 0.
